// File: rtl/player_volume_adjust.sv
// Audio clip player with volume stage.
// A sample-rate divider on mclk paces a fractional phase accumulator that
// walks a CLIP_LEN-entry waveform table; each sample period the selected
// entry is registered and strobed with valid, then scaled by volume
// combinationally on its way to the mixer.
module player_volume_adjust #(
    parameter int CLIP_LEN      = 64,
    parameter int FREQ_RES_BITS = 16,
    parameter int FRAC_BITS     = 8,
    parameter int VOLUME_BITS   = 8,
    parameter int SAMPLE_DIV    = 256
) (
    input  logic                     mclk,
    input  logic                     rst,
    input  logic [FREQ_RES_BITS-1:0] p_frequency,
    input  logic [VOLUME_BITS-1:0]   volume,
    input  logic signed [15:0]       data_buffer [0:CLIP_LEN-1],
    output logic signed [15:0]       player_sample,
    output logic signed [15:0]       sample_out,
    output logic                     valid
);

    localparam int IDX_BITS   = $clog2(CLIP_LEN);
    localparam int DIV_BITS   = $clog2(SAMPLE_DIV);
    localparam int PHASE_BITS = IDX_BITS + FRAC_BITS;
    localparam int PROD_BITS  = 16 + VOLUME_BITS + 1;

    localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(SAMPLE_DIV - 1);

    logic [DIV_BITS-1:0]   div_cnt;
    logic                  tick;
    logic [PHASE_BITS-1:0] phase;
    logic [PHASE_BITS-1:0] freq_inc;
    logic [IDX_BITS-1:0]   idx;

    // Phase increment: zero-extend a narrow p_frequency, drop the top bits of
    // a wide one (those bits would only add whole laps of the table).
    generate
        if (FREQ_RES_BITS >= PHASE_BITS) begin : g_inc_trunc
            assign freq_inc = p_frequency[PHASE_BITS-1:0];
        end else begin : g_inc_ext
            assign freq_inc = {{(PHASE_BITS - FREQ_RES_BITS){1'b0}}, p_frequency};
        end
    endgenerate

    assign tick = (div_cnt == DIV_LAST);
    assign idx  = phase[PHASE_BITS-1:FRAC_BITS];

    // Sample-rate divider: free-running count of mclk cycles within a sample.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Once per sample: latch the table entry at the current phase, then step
    // the phase. Modular overflow of phase gives seamless table wrap.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            phase         <= '0;
            player_sample <= '0;
            valid         <= 1'b0;
        end else begin
            valid <= tick;
            if (tick) begin
                player_sample <= data_buffer[idx];
                phase         <= phase + freq_inc;
            end
        end
    end

    // Volume stage: signed sample times unsigned gain, floor-divided by
    // 2^VOLUME_BITS. Gain is strictly below unity so the result fits 16 bits.
    logic signed [PROD_BITS-1:0] samp_ext;
    logic signed [PROD_BITS-1:0] vol_ext;

    assign samp_ext = {{(VOLUME_BITS + 1){player_sample[15]}}, player_sample};
    assign vol_ext  = {{17{1'b0}}, volume};

    always_comb begin
        sample_out = 16'((samp_ext * vol_ext) >>> VOLUME_BITS);
    end

endmodule

// File: tb/tb_player_volume_adjust.sv
// Directed bench for player_volume_adjust: reset behaviour, first-sample
// latency, table stepping and wrap, fractional rate, volume arithmetic,
// mid-run reset and a frequency change between ticks.
module tb_player_volume_adjust;

    logic               mclk;
    logic               rst;
    logic [15:0]        p_frequency;
    logic [7:0]         volume;
    logic signed [15:0] data_buffer [0:63];
    logic signed [15:0] player_sample;
    logic signed [15:0] sample_out;
    logic               valid;

    int tests_run = 0;
    int tests_failed = 0;

    player_volume_adjust #(
        .CLIP_LEN(64), .FREQ_RES_BITS(16), .FRAC_BITS(8),
        .VOLUME_BITS(8), .SAMPLE_DIV(256)
    ) dut (
        .mclk(mclk), .rst(rst), .p_frequency(p_frequency), .volume(volume),
        .data_buffer(data_buffer), .player_sample(player_sample),
        .sample_out(sample_out), .valid(valid)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Count negedges until valid is seen; n = 256 means the tick was the
    // 256th rising edge since the reference negedge. 0 marks a timeout.
    task automatic wait_valid(output int n);
        n = 0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge mclk);
            if (valid) begin
                n = k;
                break;
            end
        end
        if (n == 0) chk("valid_timeout", 0, 1);
    endtask

    // Hold reset a few cycles checking the cleared outputs, release on a negedge.
    task automatic do_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge mclk);
            chk("rst_valid", int'(valid), 0);
            chk("rst_ps", int'(player_sample), 0);
            chk("rst_so", int'(sample_out), 0);
        end
        rst = 1'b0;
    endtask

    function automatic int tbl(input int i);
        logic signed [15:0] v;
        v = 16'(1000 * i);
        return int'(v);
    endfunction

    task automatic load_ramp();
        for (int i = 0; i < 64; i++) data_buffer[i] = 16'(1000 * i);
    endtask

    int n;

    initial begin
        rst = 1'b1;
        p_frequency = 16'd256;
        volume = 8'd255;
        load_ramp();

        // Reset and first two samples.
        do_reset();
        wait_valid(n);
        chk("first_latency", n, 256);
        chk("first_ps", int'(player_sample), 0);
        chk("first_so", int'(sample_out), 0);
        @(negedge mclk);
        chk("valid_one_cycle", int'(valid), 0);
        wait_valid(n);
        chk("second_gap", n, 255);
        chk("second_ps", int'(player_sample), 1000);
        chk("second_so", int'(sample_out), 996);

        // Continue through entries 2..63 and wrap back to 0.
        for (int i = 2; i <= 64; i++) begin
            wait_valid(n);
            chk("step_gap", n, 256);
            chk("step_ps", int'(player_sample), tbl(i % 64));
        end

        // Double rate: even entries, then wrap to 0.
        p_frequency = 16'd512;
        do_reset();
        for (int i = 0; i <= 32; i++) begin
            wait_valid(n);
            chk("dbl_ps", int'(player_sample), tbl((2 * i) % 64));
        end

        // Half rate: each entry on two consecutive valids.
        p_frequency = 16'd128;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wait_valid(n);
            chk("half_ps", int'(player_sample), tbl(i / 2));
        end

        // Mid-run reset at div_cnt = 100 with phase nonzero.
        p_frequency = 16'd256;
        do_reset();
        wait_valid(n);
        wait_valid(n);
        chk("mid_pre_ps", int'(player_sample), 1000);
        repeat (100) @(negedge mclk);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_ps", int'(player_sample), 0);
        chk("mid_rst_so", int'(sample_out), 0);
        @(negedge mclk);
        rst = 1'b0;
        wait_valid(n);
        chk("mid_restart_latency", n, 256);
        chk("mid_restart_ps", int'(player_sample), 0);
        wait_valid(n);
        chk("mid_restart_ps2", int'(player_sample), 1000);

        // Frequency change between ticks.
        p_frequency = 16'd256;
        do_reset();
        wait_valid(n);
        chk("fchg_ps0", int'(player_sample), 0);
        repeat (10) @(negedge mclk);
        p_frequency = 16'd1024;
        wait_valid(n);
        chk("fchg_gap", n, 246);
        chk("fchg_ps1", int'(player_sample), 1000);
        wait_valid(n);
        chk("fchg_ps5", int'(player_sample), 5000);
        wait_valid(n);
        chk("fchg_ps9", int'(player_sample), 9000);

        // Volume arithmetic, frequency 0 holds entry 0.
        p_frequency = 16'd0;
        data_buffer[0] = 16'sd32767;
        do_reset();
        wait_valid(n);
        chk("vol_ps_max", int'(player_sample), 32767);
        volume = 8'd128; #1;
        chk("vol_max_128", int'(sample_out), 16383);
        volume = 8'd255; #1;
        chk("vol_max_255", int'(sample_out), 32639);
        volume = 8'd0; #1;
        chk("vol_max_0", int'(sample_out), 0);
        data_buffer[0] = -16'sd32768;
        wait_valid(n);
        chk("vol_ps_min", int'(player_sample), -32768);
        volume = 8'd255; #1;
        chk("vol_min_255", int'(sample_out), -32640);
        volume = 8'd1; #1;
        chk("vol_min_1", int'(sample_out), -128);
        volume = 8'd0; #1;
        chk("vol_min_0", int'(sample_out), 0);
        data_buffer[0] = -16'sd1;
        wait_valid(n);
        chk("vol_ps_m1", int'(player_sample), -1);
        volume = 8'd1; #1;
        chk("vol_m1_1", int'(sample_out), -1);
        // Table changes between ticks must not reach the output.
        data_buffer[0] = 16'sd1234;
        repeat (5) @(negedge mclk);
        chk("hold_between_ticks", int'(player_sample), -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
